// File: rtl/mod12_disp_pkg.sv
// -----------------------------------------------------------------------------
// mod12_disp_pkg
// Shared constants and types for the mod-12 seven-segment display stage:
//   - active-low segment encodings ({g,f,e,d,c,b,a}) for digits 0..9, 'E', blank
//   - active-low anode patterns for "all off", ones digit and tens digit
//   - scan_sel_t naming which digit slot is being refreshed
//   - split_digits(): splits a 4-bit counter value into tens/ones digits
// No ports (package).
// -----------------------------------------------------------------------------
package mod12_disp_pkg;

    localparam int unsigned DIN_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned DIGIT_W = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low anode enables; an[3:2] are never driven low.
    localparam logic [AN_W-1:0] AN_OFF = 4'b1111;
    localparam logic [AN_W-1:0] AN_D0  = 4'b1110;
    localparam logic [AN_W-1:0] AN_D1  = 4'b1101;

    // Digit code fed to the decoder for an out-of-range counter value.
    localparam logic [DIGIT_W-1:0] DIGIT_ERR = 4'hE;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } scan_sel_t;

    typedef struct packed {
        logic               valid;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } digits_t;

    // Split a mod-12 value into decimal digits; 12..15 are flagged invalid
    // and carry the error code in the ones position.
    function automatic digits_t split_digits(input logic [DIN_W-1:0] v);
        digits_t d;
        d.valid = 1'b1;
        d.tens  = '0;
        d.ones  = DIGIT_W'(v);
        if (v > DIN_W'(11)) begin
            d.valid = 1'b0;
            d.tens  = '0;
            d.ones  = DIGIT_ERR;
        end else if (v > DIN_W'(9)) begin
            d.tens  = DIGIT_W'(1);
            d.ones  = DIGIT_W'(v - DIN_W'(10));
        end
        return d;
    endfunction

endpackage : mod12_disp_pkg

// File: rtl/mod12_seg7_disp_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 all display 'E'.
// Ports:
//   digit  in  4  digit code
//   seg    out 7  segments {g,f,e,d,c,b,a}, active-low (combinational)
// -----------------------------------------------------------------------------
module seg7_decode
    import mod12_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);

    // Explicit case keeps the table lookup in range for every input code.
    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_E;
        endcase
    end

endmodule : seg7_decode

// File: rtl/mod12_seg7_disp.sv
// -----------------------------------------------------------------------------
// mod12_seg7_disp
// Display stage for a mod-12 counter: captures the value, splits it into two
// decimal digits and time-multiplexes them onto a common-anode 4-digit
// seven-segment display, with an all-anodes-off guard window at the start of
// every digit slot to prevent ghosting.
//
// Build option: define LEADING_ZERO_BLANK_EN to leave the tens digit fully
// dark when it is a leading zero (default: the tens digit shows '0').
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 4)
//   GUARD_CYC    dark cycles at the start of each slot (1..REFRESH_DIV-2)
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous, active-high reset
//   din      in  4  counter value to display
//   din_vld  in  1  capture strobe for din
//   an       out 4  anode enables, active-low (registered)
//   seg      out 7  segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp       out 1  decimal point, active-low, held off
// -----------------------------------------------------------------------------
module mod12_seg7_disp
    import mod12_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100_000,
    parameter int unsigned GUARD_CYC   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] din,
    input  logic             din_vld,
    output logic [AN_W-1:0]  an,
    output logic [SEG_W-1:0] seg,
    output logic             dp
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_BLANK = 1'b1;
`else
    localparam bit LZ_BLANK = 1'b0;
`endif

    logic [DIN_W-1:0] din_q,     din_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    scan_sel_t        scan_sel_q, scan_sel_d;
    logic [AN_W-1:0]  an_q,      an_d;
    logic [SEG_W-1:0] seg_q,     seg_d;

    logic             wrap_c;
    digits_t          digits_c;
    logic [DIGIT_W-1:0] dec_digit_c;
    logic [SEG_W-1:0] dec_seg_c;
    logic             tens_dark_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q      <= '0;
            ref_cnt_q  <= '0;
            scan_sel_q <= ONES;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            din_q      <= din_d;
            ref_cnt_q  <= ref_cnt_d;
            scan_sel_q <= scan_sel_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Next state: capture and refresh counter. Capture and slot wrap are
    // independent, so a strobe on the wrap cycle simply does both.
    always_comb begin
        din_d      = din_q;
        ref_cnt_d  = ref_cnt_q + CNT_W'(1);
        scan_sel_d = scan_sel_q;
        wrap_c     = (ref_cnt_q == CNT_MAX);

        if (din_vld) begin
            din_d = din;
        end

        if (wrap_c) begin
            ref_cnt_d  = '0;
            scan_sel_d = (scan_sel_q == ONES) ? TENS : ONES;
        end
    end

    // Digit split and the single shared decoder, steered by the active slot.
    always_comb begin
        digits_c    = split_digits(din_q);
        dec_digit_c = (scan_sel_q == ONES) ? digits_c.ones : digits_c.tens;
        // Tens slot stays dark for invalid values, and for a leading zero
        // when blanking is enabled.
        tens_dark_c = !digits_c.valid
                   || (LZ_BLANK && (digits_c.tens == '0));
    end

    seg7_decode u_decode (
        .digit (dec_digit_c),
        .seg   (dec_seg_c)
    );

    // Output next values: guard window first, then the active digit.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;

        if (ref_cnt_q >= GUARD_END) begin
            if (scan_sel_q == ONES) begin
                an_d  = AN_D0;
                seg_d = dec_seg_c;
            end else if (!tens_dark_c) begin
                an_d  = AN_D1;
                seg_d = dec_seg_c;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule : mod12_seg7_disp
